mem_line_arbiter: RTL and testbench

MEM_LINE_ARBITER -- requirements
Module: mem_line_arbiter

---
 rtl/mem_line_arbiter_if.sv | 39 +++
 rtl/mem_line_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_line_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_line_arbiter_if.sv
// Requester-side bundle for one port of the line-burst memory arbiter.
// The arbiter owns the slave view, each requester the master view.
interface mem_line_arbiter_if #(
    parameter int ADDR_LEN = 11
);
    logic                req;
    logic                wr;
    logic [ADDR_LEN-1:0] addr;
    logic [31:0]         wr_data;
    logic                gnt;
    logic                wr_ready;
    logic                rd_valid;
    logic [31:0]         rd_data;
    logic                done;

    modport master (
        output req,
        output wr,
        output addr,
        output wr_data,
        input  gnt,
        input  wr_ready,
        input  rd_valid,
        input  rd_data,
        input  done
    );

    modport slave (
        input  req,
        input  wr,
        input  addr,
        input  wr_data,
        output gnt,
        output wr_ready,
        output rd_valid,
        output rd_data,
        output done
    );
endinterface

// File: rtl/mem_line_arbiter.sv
// Two-port round-robin arbiter moving whole aligned lines to/from a
// shared single-port memory with one-cycle read latency.
module mem_line_arbiter #(
    parameter int ADDR_LEN = 11,
    parameter int LINE_LEN = 3
) (
    input  logic                clk,
    input  logic                rst,
    mem_line_arbiter_if.slave   port0,
    mem_line_arbiter_if.slave   port1,
    output logic [LINE_LEN-1:0] beat,
    output logic                busy,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic                mem_wr_req,
    output logic [31:0]         mem_wr_data,
    input  logic [31:0]         mem_rd_data
);

    localparam int BASE_W = ADDR_LEN - LINE_LEN;
    localparam logic [LINE_LEN-1:0] LAST_BEAT = '1;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        RD_DRAIN,
        WR_BURST
    } state_e;

    state_e              state_q, state_d;
    logic [LINE_LEN-1:0] beat_q, beat_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic                rd_valid_q, rd_valid_d;

    logic                sel;
    logic                sel_wr;
    logic                in_burst;
    logic                first_beat;
    logic                last_beat;

    // Low line bits of the request address are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{port0.addr[LINE_LEN-1:0],
                                port1.addr[LINE_LEN-1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            base_q     <= '0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            base_q     <= base_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        base_d     = base_q;
        owner_d    = owner_q;
        last_d     = last_q;
        rd_valid_d = (state_q == RD_BURST);
        sel        = 1'b0;
        sel_wr     = 1'b0;

        unique case (state_q)
            IDLE: begin
                beat_d = '0;
                // On a tie the port that was not granted last wins.
                if (port0.req && port1.req) begin
                    sel = ~last_q;
                end else begin
                    sel = port1.req;
                end
                sel_wr = sel ? port1.wr : port0.wr;
                if (port0.req || port1.req) begin
                    owner_d = sel;
                    last_d  = sel;
                    base_d  = sel ? port1.addr[ADDR_LEN-1:LINE_LEN]
                                  : port0.addr[ADDR_LEN-1:LINE_LEN];
                    state_d = sel_wr ? WR_BURST : RD_BURST;
                end
            end
            RD_BURST: begin
                beat_d = beat_q + LINE_LEN'(1);
                if (beat_q == LAST_BEAT) begin
                    state_d = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                beat_d  = '0;
                state_d = IDLE;
            end
            WR_BURST: begin
                beat_d = beat_q + LINE_LEN'(1);
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                end
            end
            default: begin
                beat_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        in_burst   = (state_q == RD_BURST) || (state_q == WR_BURST);
        first_beat = in_burst && (beat_q == '0);
        last_beat  = ((state_q == WR_BURST) && (beat_q == LAST_BEAT))
                   || (state_q == RD_DRAIN);
        mem_wr_req = (state_q == WR_BURST);
        mem_addr   = in_burst ? {base_q, beat_q} : '0;
        if (mem_wr_req) begin
            mem_wr_data = owner_q ? port1.wr_data : port0.wr_data;
        end else begin
            mem_wr_data = '0;
        end
    end

    assign port0.gnt      = first_beat && !owner_q;
    assign port1.gnt      = first_beat &&  owner_q;
    assign port0.wr_ready = mem_wr_req && !owner_q;
    assign port1.wr_ready = mem_wr_req &&  owner_q;
    assign port0.rd_valid = rd_valid_q && !owner_q;
    assign port1.rd_valid = rd_valid_q &&  owner_q;
    assign port0.done     = last_beat  && !owner_q;
    assign port1.done     = last_beat  &&  owner_q;
    assign port0.rd_data  = mem_rd_data;
    assign port1.rd_data  = mem_rd_data;

    assign beat = beat_q;
    assign busy = (state_q != IDLE);

    a_one_grant: assert property (
        @(posedge clk) disable iff (!rst)
        !(port0.gnt && port1.gnt));

    a_one_owner: assert property (
        @(posedge clk) disable iff (!rst)
        !(port0.wr_ready && port1.wr_ready)
        && !(port0.rd_valid && port1.rd_valid));

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Scoreboard bench for mem_line_arbiter: behavioural memory, two
// requester agents, expected read words and grant order in queues.
module tb_mem_line_arbiter;

    localparam int AW = 11;
    localparam int LL = 3;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [LL-1:0] beat;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_req;
    logic [31:0]   mem_wr_data;
    logic [31:0]   mem_rd_data;

    always #5 clk = ~clk;

    mem_line_arbiter_if #(.ADDR_LEN(AW)) i0 ();
    mem_line_arbiter_if #(.ADDR_LEN(AW)) i1 ();

    mem_line_arbiter #(.ADDR_LEN(AW), .LINE_LEN(LL)) dut (
        .clk         (clk),
        .rst         (rst),
        .port0       (i0),
        .port1       (i1),
        .beat        (beat),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    function automatic logic [31:0] init_word(int i);
        case (i)
            0:       return 32'h0000_000f;
            1:       return 32'h0000_00f0;
            8:       return 32'h0000_00ab;
            default: return 32'hA500_0000 | i;
        endcase
    endfunction

    logic [31:0] mem     [0:2047];
    logic [31:0] ref_mem [0:2047];
    logic        load;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 2048; i++) mem[i] <= init_word(i);
        end else if (mem_wr_req) begin
            mem[mem_addr] <= mem_wr_data;
        end
        mem_rd_data <= mem[mem_addr];
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rd0 [$];
    logic [31:0] exp_rd1 [$];
    int          gq [$];
    int          k0, k1;
    logic [31:0] wb0, wb1;
    logic        wp0, wp1;

    // Layout: port1 {gnt,wr_ready,rd_valid,done}, port0 same, busy, mem_wr_req
    function automatic logic [9:0] obs();
        return {i1.gnt, i1.wr_ready, i1.rd_valid, i1.done,
                i0.gnt, i0.wr_ready, i0.rd_valid, i0.done,
                busy, mem_wr_req};
    endfunction

    function automatic logic [9:0] pv(int p, logic g, logic w,
                                      logic r, logic d);
        logic [3:0] v;
        v = {g, w, r, d};
        return (p == 1) ? {v, 6'b0} : {4'b0, v, 2'b0};
    endfunction

    task automatic pop_exp(input int p, output logic [31:0] v,
                           output bit ok);
        ok = 1'b0;
        v  = '0;
        if (p == 0 && exp_rd0.size() > 0) begin
            v = exp_rd0.pop_front(); ok = 1'b1;
        end else if (p == 1 && exp_rd1.size() > 0) begin
            v = exp_rd1.pop_front(); ok = 1'b1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (wp0) begin k0++; i0.wr_data = wb0 + 32'(k0); end
        wp0 = i0.wr_ready;
        if (i0.gnt) i0.req = 1'b0;
        if (wp1) begin k1++; i1.wr_data = wb1 + 32'(k1); end
        wp1 = i1.wr_ready;
        if (i1.gnt) i1.req = 1'b0;
    endtask

    task automatic start(input int p, input logic wr,
                         input logic [AW-1:0] a, input logic [31:0] d);
        logic [AW-1:0] ln;
        ln = {a[AW-1:LL], {LL{1'b0}}};
        for (int j = 0; j < N; j++) begin
            if (wr) ref_mem[ln + j] = d + 32'(j);
            else if (p == 0) exp_rd0.push_back(ref_mem[ln + j]);
            else exp_rd1.push_back(ref_mem[ln + j]);
        end
        if (p == 0) begin
            i0.req = 1'b1; i0.wr = wr; i0.addr = a; i0.wr_data = d;
            wb0 = d; k0 = 0; wp0 = 1'b0;
        end else begin
            i1.req = 1'b1; i1.wr = wr; i1.addr = a; i1.wr_data = d;
            wb1 = d; k1 = 0; wp1 = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        load = 1'b1;
        i0.req = 0; i0.wr = 0; i0.addr = '0; i0.wr_data = '0;
        i1.req = 0; i1.wr = 0; i1.addr = '0; i1.wr_data = '0;
        wp0 = 0; wp1 = 0; k0 = 0; k1 = 0; wb0 = '0; wb1 = '0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
        #1;
        n_checks++;
        if (obs() !== 10'b0 || mem_addr !== '0 || beat !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: obs %b addr %h beat %0d, want all 0",
                     obs(), mem_addr, beat);
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        rst  = 1'b1;
        cycle();
        n_checks++;
        if (obs() !== 10'b0 || mem_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: obs %b addr %h, want all 0",
                     obs(), mem_addr);
        end
    endtask

    task automatic run_single(input string name, input int p,
                              input logic wr, input logic [AW-1:0] a,
                              input logic [31:0] d);
        logic [9:0]    e;
        logic [AW-1:0] ea;
        logic [31:0]   ev, rdd;
        logic          rv, wrr, bsy;
        bit            ok;
        start(p, wr, a, d);
        for (int c = 1; c <= 11; c++) begin
            cycle();
            wrr = wr && (c <= 8);
            bsy = wr ? (c <= 8) : (c <= 9);
            e = pv(p, c == 1, wrr, !wr && c >= 2 && c <= 9,
                   wr ? (c == 8) : (c == 9)) | {8'b0, bsy, wrr};
            ea = (c <= 8) ? {a[AW-1:LL], LL'(c - 1)} : '0;
            n_checks++;
            if (obs() !== e || mem_addr !== ea) begin
                n_fail++;
                $display("FAIL %s cyc %0d: obs %b addr %h, want %b addr %h",
                         name, c, obs(), mem_addr, e, ea);
            end
            rv  = (p == 1) ? i1.rd_valid : i0.rd_valid;
            rdd = (p == 1) ? i1.rd_data  : i0.rd_data;
            if (rv) begin
                pop_exp(p, ev, ok);
                n_checks++;
                if (!ok || rdd !== ev) begin
                    n_fail++;
                    $display("FAIL %s_data cyc %0d: got %h, want %h (queued %0d)",
                             name, c, rdd, ev, ok);
                end
            end
        end
        n_checks++;
        if (exp_rd0.size() != 0 || exp_rd1.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d/%0d words never returned, want 0",
                     name, exp_rd0.size(), exp_rd1.size());
            exp_rd0.delete(); exp_rd1.delete();
        end
        if (wr) begin
            for (int j = 0; j < N; j++) begin
                n_checks++;
                if (mem[{a[AW-1:LL], LL'(j)}] !== ref_mem[{a[AW-1:LL], LL'(j)}]) begin
                    n_fail++;
                    $display("FAIL %s_mem word %0d: got %h, want %h", name, j,
                             mem[{a[AW-1:LL], LL'(j)}],
                             ref_mem[{a[AW-1:LL], LL'(j)}]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int          mask  [4] = '{3, 3, 1, 3};
        int          first [4] = '{0, 0, 0, 1};
        logic [31:0] ev;
        bit          ok;
        int          got;
        for (int r = 0; r < 4; r++) begin
            if (r == 0) rst = 1'b0;
            if (mask[r][0]) start(0, 1'b0, 11'h100 + 11'(r * 16), 32'h0);
            if (mask[r][1]) start(1, 1'b0, 11'h108 + 11'(r * 16), 32'h0);
            if (mask[r] == 3) begin
                gq.push_back(first[r]);
                gq.push_back(1 - first[r]);
            end else begin
                gq.push_back(0);
            end
            if (r == 0) begin #2; rst = 1'b1; end
            for (int c = 0; c < 60; c++) begin
                if (gq.size() == 0 && exp_rd0.size() == 0 &&
                    exp_rd1.size() == 0 && !busy) break;
                cycle();
                if (i0.gnt || i1.gnt) begin
                    got = i1.gnt ? 1 : 0;
                    n_checks++;
                    if (gq.size() == 0 || (i0.gnt && i1.gnt) ||
                        got != gq[0]) begin
                        n_fail++;
                        $display("FAIL rr_order round %0d: gnt0 %b gnt1 %b, want port %0d",
                                 r, i0.gnt, i1.gnt,
                                 (gq.size() > 0) ? gq[0] : -1);
                    end
                    if (gq.size() > 0) void'(gq.pop_front());
                end
                if (i0.rd_valid) begin
                    pop_exp(0, ev, ok);
                    n_checks++;
                    if (!ok || i0.rd_data !== ev) begin
                        n_fail++;
                        $display("FAIL rr_data0 round %0d: got %h, want %h",
                                 r, i0.rd_data, ev);
                    end
                end
                if (i1.rd_valid) begin
                    pop_exp(1, ev, ok);
                    n_checks++;
                    if (!ok || i1.rd_data !== ev) begin
                        n_fail++;
                        $display("FAIL rr_data1 round %0d: got %h, want %h",
                                 r, i1.rd_data, ev);
                    end
                end
                n_checks++;
                if (mem_wr_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rr_no_write round %0d: mem_wr_req %b, want 0",
                             r, mem_wr_req);
                end
            end
            n_checks++;
            if (gq.size() != 0 || exp_rd0.size() != 0 ||
                exp_rd1.size() != 0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_timeout round %0d: %0d grants %0d/%0d words left busy %b, want none",
                         r, gq.size(), exp_rd0.size(), exp_rd1.size(), busy);
                gq.delete(); exp_rd0.delete(); exp_rd1.delete();
            end
        end
    endtask

    task automatic test_hold();
        logic [9:0]  e;
        logic [31:0] ev;
        logic        bsy;
        bit          ok;
        start(0, 1'b1, 11'h040, 32'h200);
        for (int c = 1; c <= 20; c++) begin
            cycle();
            bsy = (c <= 8) || (c >= 10 && c <= 18);
            e = pv(0, c == 1, c <= 8, 1'b0, c == 8)
              | pv(1, c == 10, 1'b0, c >= 11 && c <= 18, c == 18)
              | {8'b0, bsy, c <= 8};
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL hold cyc %0d: obs %b, want %b", c, obs(), e);
            end
            if (i1.rd_valid) begin
                pop_exp(1, ev, ok);
                n_checks++;
                if (!ok || i1.rd_data !== ev) begin
                    n_fail++;
                    $display("FAIL hold_data cyc %0d: got %h, want %h",
                             c, i1.rd_data, ev);
                end
            end
            if (c == 1) start(1, 1'b0, 11'h040, 32'h0);
        end
        n_checks++;
        if (exp_rd1.size() != 0) begin
            n_fail++;
            $display("FAIL hold_drain: %0d words left, want 0", exp_rd1.size());
            exp_rd1.delete();
        end
    endtask

    task automatic test_reset_mid();
        start(0, 1'b1, 11'h050, 32'h300);
        for (int j = 3; j < N; j++) ref_mem[11'h050 + j] = init_word(16'h50 + j);
        for (int c = 1; c <= 4; c++) cycle();
        n_checks++;
        if ({mem_wr_req, beat} !== {1'b1, 3'd3}) begin
            n_fail++;
            $display("FAIL rstmid_beat3: wr_req %b beat %0d, want 1 and 3",
                     mem_wr_req, beat);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 10'b0 || mem_addr !== '0 || beat !== '0) begin
            n_fail++;
            $display("FAIL rstmid_now: obs %b addr %h beat %0d, want all 0",
                     obs(), mem_addr, beat);
        end
        repeat (2) begin
            cycle();
            n_checks++;
            if (obs() !== 10'b0) begin
                n_fail++;
                $display("FAIL rstmid_hold: obs %b, want 0", obs());
            end
        end
        rst = 1'b1;
        for (int j = 0; j < N; j++) begin
            n_checks++;
            if (mem[11'h050 + j] !== ref_mem[11'h050 + j]) begin
                n_fail++;
                $display("FAIL rstmid_mem word %0d: got %h, want %h", j,
                         mem[11'h050 + j], ref_mem[11'h050 + j]);
            end
        end
        run_single("after_rst", 1, 1'b0, 11'h050, 32'h0);
    endtask

    initial begin
        test_reset();
        run_single("read0",     0, 1'b0, 11'h000, 32'h0);
        run_single("write1",    1, 1'b1, 11'h013, 32'h100);
        run_single("readback1", 1, 1'b0, 11'h010, 32'h0);
        run_single("read_top",  0, 1'b0, 11'h7F8, 32'h0);
        run_single("read_w8",   0, 1'b0, 11'h008, 32'h0);
        test_round_robin();
        test_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
